id_decode_stage: RTL and testbench

Decode/issue pipeline stage that feeds the execute-stage ALU. It accepts one RV32I instruction per cycle with its PC and register-file read data, and derives the 4-bit ALU operation code and both operands. The results are held in a valid/ready output register. The stage covers the OP, OP-IMM, LUI and AUIPC opcode classes; every other opcode is flagged illegal and issued as a harmless non-writing bubble.

---
 rtl/id_decode_stage.sv | 169 ++++++++++++++++
 tb/tb_id_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// RV32I decode/issue stage: derives ALU op and operands for OP, OP-IMM, LUI and AUIPC
// into a valid/ready output register. Define ID_SKID_BUFFER_EN to add a one-entry skid register.
module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_opr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        illegal,
  output logic [31:0] pc_out
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [3:0]  opr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } entry_t;

  entry_t      dec_d;
  entry_t      out_q;
  logic        out_valid_q;
  logic        load;
  logic        legal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Every supported opcode ends in 2'b11, so a compressed-looking word falls to default.
  always_comb begin
    dec_d    = '0;
    dec_d.rd = instr[11:7];
    dec_d.pc = pc;
    legal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        dec_d.opr = {instr[30], funct3};
        dec_d.a   = rs1_data;
        dec_d.b   = rs2_data;
      end
      OPC_OPIMM: begin
        legal   = 1'b1;
        dec_d.a = rs1_data;
        if (funct3 == 3'b101) begin
          dec_d.opr = {instr[30], 3'b101};
          dec_d.b   = {27'b0, instr[24:20]};
        end else begin
          dec_d.opr = {1'b0, funct3};
          dec_d.b   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_LUI: begin
        legal     = 1'b1;
        dec_d.opr = 4'b0000;
        dec_d.a   = '0;
        dec_d.b   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        dec_d.opr = 4'b0000;
        dec_d.a   = pc;
        dec_d.b   = {instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_d.opr = '0;
      dec_d.a   = '0;
      dec_d.b   = '0;
    end
    dec_d.illegal = !legal;
    dec_d.wb_en   = legal && (instr[11:7] != 5'd0);
  end

`ifdef ID_SKID_BUFFER_EN
  entry_t skid_q;
  logic   skid_valid_q;
  logic   out_free;

  assign in_ready = !skid_valid_q;
  assign load     = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // A full skid blocks in_ready, so it and a new load are never both pending here.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (load) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (load) begin
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      // NOTE: payload is reset too because downstream observes zeroed fields after reset.
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_q       <= dec_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign alu_opr   = out_q.opr;
  assign alu_a     = out_q.a;
  assign alu_b     = out_q.b;
  assign rd        = out_q.rd;
  assign wb_en     = out_q.wb_en;
  assign illegal   = out_q.illegal;
  assign pc_out    = out_q.pc;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: decode vector table plus backpressure,
// flush and mid-stream reset sequences.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;
  logic [31:0] pc_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opr(alu_opr),
    .alu_a(alu_a), .alu_b(alu_b), .rd(rd), .wb_en(wb_en),
    .illegal(illegal), .pc_out(pc_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  opr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".alu_opr"},   alu_opr,   0);
    check({tag, ".alu_a"},     alu_a,     0);
    check({tag, ".alu_b"},     alu_b,     0);
    check({tag, ".rd"},        rd,        0);
    check({tag, ".wb_en"},     wb_en,     0);
    check({tag, ".illegal"},   illegal,   0);
    check({tag, ".pc_out"},    pc_out,    0);
    check({tag, ".in_ready"},  in_ready,  1);
  endtask

  initial begin
    logic [31:0] words[3];
    logic        exp_rdy;
    logic        fire_in;
    logic        fire_out;
    int          k;
    int          got;

    //            instr          pc          rs1           rs2          opr      a             b             rd     wb    ill
    vecs[0]  = '{32'h40B50533, 32'h000, 32'd10,        32'd3,       4'b1000, 32'd10,        32'd3,        5'd10, 1'b1, 1'b0};
    vecs[1]  = '{32'h4041D193, 32'h004, 32'h80000000,  32'd5,       4'b1101, 32'h80000000,  32'd4,        5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'hFFF00093, 32'h008, 32'd0,         32'd7,       4'b0000, 32'd0,         32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
    vecs[3]  = '{32'h123452B7, 32'h00C, 32'hDEAD,      32'hBEEF,    4'b0000, 32'd0,         32'h12345000, 5'd5,  1'b1, 1'b0};
    vecs[4]  = '{32'h12345317, 32'h100, 32'hDEAD,      32'hBEEF,    4'b0000, 32'h100,       32'h12345000, 5'd6,  1'b1, 1'b0};
    vecs[5]  = '{32'h0000006F, 32'h200, 32'h55,        32'h66,      4'b0000, 32'd0,         32'd0,        5'd0,  1'b0, 1'b1};
    vecs[6]  = '{32'h00208033, 32'h204, 32'd5,         32'd6,       4'b0000, 32'd5,         32'd6,        5'd0,  1'b0, 1'b0};
    vecs[7]  = '{32'h022080B3, 32'h208, 32'd5,         32'd6,       4'b0000, 32'd0,         32'd0,        5'd1,  1'b0, 1'b1};
    vecs[8]  = '{32'h4020F0B3, 32'h20C, 32'd5,         32'd6,       4'b0000, 32'd0,         32'd0,        5'd1,  1'b0, 1'b1};
    vecs[9]  = '{32'h00A00092, 32'h210, 32'd5,         32'd6,       4'b0000, 32'd0,         32'd0,        5'd1,  1'b0, 1'b1};
    vecs[10] = '{32'h8000C113, 32'h214, 32'h0F0F0F0F,  32'd9,       4'b0100, 32'h0F0F0F0F,  32'hFFFFF800, 5'd2,  1'b1, 1'b0};
    vecs[11] = '{32'h0020D1B3, 32'h218, 32'hF0000000,  32'd4,       4'b0101, 32'hF0000000,  32'd4,        5'd3,  1'b1, 1'b0};
    vecs[12] = '{32'h4020D1B3, 32'h21C, 32'hF0000000,  32'd4,       4'b1101, 32'hF0000000,  32'd4,        5'd3,  1'b1, 1'b0};
    vecs[13] = '{32'h01F0D213, 32'h220, 32'd1,         32'd2,       4'b0101, 32'd1,         32'd31,       5'd4,  1'b1, 1'b0};
    vecs[14] = '{32'h4000A093, 32'h224, 32'h123,       32'd2,       4'b0010, 32'h123,       32'h400,      5'd1,  1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    check_zero("rst");
    rst = 1'b0;
    step();
    check_zero("post_rst");

    instr = 32'h40B50533;
    #1;
    check("rs1_addr", rs1_addr, 10);
    check("rs2_addr", rs2_addr, 11);

    // Back-to-back issue with out_ready held high: each word visible one edge later.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; pc = vecs[i].pc;
      rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
      step();
      check($sformatf("v%0d.out_valid", i), out_valid, 1);
      check($sformatf("v%0d.alu_opr", i),   alu_opr,   vecs[i].opr);
      check($sformatf("v%0d.alu_a", i),     alu_a,     vecs[i].a);
      check($sformatf("v%0d.alu_b", i),     alu_b,     vecs[i].b);
      check($sformatf("v%0d.rd", i),        rd,        vecs[i].rd);
      check($sformatf("v%0d.wb_en", i),     wb_en,     vecs[i].wb);
      check($sformatf("v%0d.illegal", i),   illegal,   vecs[i].ill);
      check($sformatf("v%0d.pc_out", i),    pc_out,    vecs[i].pc);
    end
    in_valid = 1'b0;
    step();
    check("drain.out_valid", out_valid, 0);

    // Backpressure: three stalled cycles, then stream must deliver 1,2,3 exactly once in order.
    words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h00300193;
    k = 0; got = 0; rs1_data = '0; rs2_data = '0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      out_ready = (c >= 4);
      in_valid  = (k < 3);
      instr     = (k < 3) ? words[k] : 32'h0;
      pc        = 32'(k * 4);
      #1;
      if (c >= 1 && c <= 3) begin
`ifdef ID_SKID_BUFFER_EN
        exp_rdy = (c == 1);
`else
        exp_rdy = 1'b0;
`endif
        check($sformatf("bp.in_ready.c%0d", c), in_ready,  exp_rdy);
        check($sformatf("bp.hold_valid.c%0d", c), out_valid, 1);
        check($sformatf("bp.hold_rd.c%0d", c),  rd,        1);
        check($sformatf("bp.hold_b.c%0d", c),   alu_b,     1);
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        check($sformatf("bp.order_rd.%0d", got), rd,    got + 1);
        check($sformatf("bp.order_b.%0d", got),  alu_b, got + 1);
      end
      step();
      if (fire_in)  k++;
      if (fire_out) got++;
    end
    check("bp.accepted", k, 3);
    check("bp.delivered", got, 3);
    in_valid = 1'b0;
    step();
    check("bp.no_dup", out_valid, 0);

    // Flush with a held entry and a same-cycle input that would otherwise load.
    in_valid = 1'b1; instr = vecs[0].instr; pc = 32'h300; out_ready = 1'b0;
    step();
    check("fl.loaded", out_valid, 1);
    flush = 1'b1; instr = vecs[3].instr; out_ready = 1'b1;
    step();
    check("fl.out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("fl.dropped", out_valid, 0);

    // Reset mid-stream with input still valid.
    in_valid = 1'b1; instr = vecs[4].instr; pc = 32'h400; out_ready = 1'b0;
    step();
    check("mr.loaded", out_valid, 1);
    rst = 1'b1;
    step();
    check_zero("mr");
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("mr.after", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
